// File: rtl/seq_controller.sv
// seq_controller: Moore instruction-sequencing FSM for a small 16-bit core.
// Fetches an instruction word, decodes it out of an internal IR and sequences
// the ALU, branch/jump, load and store phases. All control outputs come from
// a register, so they are glitch-free and aligned with the state they describe.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   inst            instruction word from ROM
//   psr             status flags, psr[0]=C, psr[1]=Z
//   mem_ready       ROM/SRAM access completes this cycle
//   ir_load, pc_en  IR latched / PC advance (pulse in the DECODE cycle)
//   mem_req, mem_we memory request / SRAM write
//   reg_we          register-file write
//   BRANCH..IMM_MUX datapath selects
//   rDst, rSrc      register addresses
//   imm_val, ALU_OP immediate and ALU op-code
//   illegal,timeout sticky error flags
module seq_controller #(
  parameter int DATAWIDTH  = 16,
  parameter int REGWIDTH   = 4,
  parameter int IMMWIDTH   = 8,
  parameter int ALUOPWIDTH = 4,
  parameter int PSRWIDTH   = 5,
  parameter int WAITMAX    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATAWIDTH-1:0]  inst,
  input  logic [PSRWIDTH-1:0]   psr,
  input  logic                  mem_ready,
  output logic                  ir_load,
  output logic                  pc_en,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  reg_we,
  output logic                  BRANCH,
  output logic                  JUMP,
  output logic                  RA_BUF,
  output logic                  ROM_MUX,
  output logic                  SRAM_BUF,
  output logic                  SRAM_MUX,
  output logic                  ALU_BUF,
  output logic                  IMM_MUX,
  output logic [REGWIDTH-1:0]   rDst,
  output logic [REGWIDTH-1:0]   rSrc,
  output logic [IMMWIDTH-1:0]   imm_val,
  output logic [ALUOPWIDTH-1:0] ALU_OP,
  output logic                  illegal,
  output logic                  timeout
);

  localparam int WCW = $clog2(WAITMAX + 1);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_BRANCH, S_JUMP,
    S_JMPAL, S_LOAD0, S_LOAD1, S_STORE
  } state_t;

  typedef struct packed {
    logic                  ir_load, pc_en, mem_req, mem_we, reg_we;
    logic                  branch, jump, ra_buf, rom_mux;
    logic                  sram_buf, sram_mux, alu_buf, imm_mux;
    logic [REGWIDTH-1:0]   rdst, rsrc;
    logic [IMMWIDTH-1:0]   imm;
    logic [ALUOPWIDTH-1:0] alu_op;
  } ctl_t;

  state_t               state, state_nxt;
  logic [DATAWIDTH-1:0] ir, ir_nxt;
  logic [WCW-1:0]       wait_cnt, wait_nxt;
  logic                 ill_set, tmo_set;
  ctl_t                 ctl_q, ctl_nxt;

  logic [3:0] opc, ext;
  logic [3:0] n_opc, n_ext, n_cc, n_aop4;
  logic       n_itype, n_cond;
  logic       unused_psr;

  assign opc     = ir[15:12];
  assign ext     = ir[7:4];
  assign n_opc   = ir_nxt[15:12];
  assign n_ext   = ir_nxt[7:4];
  assign n_cc    = ir_nxt[11:8];
  // Only R-type (0000) and S-type (1000) take their op from the ext field.
  assign n_itype = (n_opc != 4'b0000) && (n_opc != 4'b1000);
  assign n_aop4  = n_itype ? n_opc : n_ext;
  assign unused_psr = ^psr[PSRWIDTH-1:2];

  // State register; outputs are registered alongside it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FETCH;
      ir       <= '0;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
      ctl_q    <= '0;
    end else begin
      state    <= state_nxt;
      ir       <= ir_nxt;
      wait_cnt <= wait_nxt;
      illegal  <= illegal | ill_set;
      timeout  <= timeout | tmo_set;
      ctl_q    <= ctl_nxt;
    end
  end

  // Next state. A memory handshake only counts while mem_req is actually
  // driven, so the reset-released FETCH first raises mem_req before it can
  // complete, and stray mem_ready pulses elsewhere are ignored.
  always_comb begin
    state_nxt = state;
    ir_nxt    = ir;
    wait_nxt  = '0;
    ill_set   = 1'b0;
    tmo_set   = 1'b0;
    case (state)
      S_FETCH: if (mem_req && mem_ready) begin
        state_nxt = S_DECODE;
        ir_nxt    = inst;
      end
      S_DECODE: begin
        state_nxt = S_FETCH;
        ill_set   = 1'b1;
        if (opc inside {4'b0101, 4'b0110, 4'b1001, 4'b1011, 4'b0001,
                        4'b0010, 4'b0011, 4'b1101, 4'b1111}) begin
          state_nxt = S_EXECUTE;
          ill_set   = 1'b0;
        end else if (opc == 4'b0000 &&
                     ext inside {4'b0101, 4'b0110, 4'b1001, 4'b1011,
                                 4'b0001, 4'b0010, 4'b0011, 4'b1101}) begin
          state_nxt = S_EXECUTE;
          ill_set   = 1'b0;
        end else if (opc == 4'b1000 &&
                     ext inside {4'b0100, 4'b0000, 4'b0001, 4'b0110,
                                 4'b0010, 4'b0011}) begin
          state_nxt = S_EXECUTE;
          ill_set   = 1'b0;
        end else if (opc == 4'b0100 &&
                     ext inside {4'b0000, 4'b0100, 4'b1100, 4'b1000}) begin
          ill_set = 1'b0;
          case (ext)
            4'b0000: state_nxt = S_LOAD0;
            4'b0100: state_nxt = S_STORE;
            4'b1100: state_nxt = S_JUMP;
            default: state_nxt = S_JMPAL;
          endcase
        end else if (opc == 4'b1100) begin
          state_nxt = S_BRANCH;
          ill_set   = 1'b0;
        end
      end
      S_LOAD0: if (mem_req && mem_ready) state_nxt = S_LOAD1;
      S_STORE: if (mem_req && mem_ready) state_nxt = S_FETCH;
      default: state_nxt = S_FETCH;
    endcase

    // Consecutive not-ready cycles; a state change leaves wait_nxt at 0.
    if ((state == S_FETCH || state == S_LOAD0 || state == S_STORE) &&
        mem_req && !mem_ready) begin
      if (wait_cnt == WCW'(WAITMAX - 1)) begin
        tmo_set   = 1'b1;
        state_nxt = S_FETCH;
      end else begin
        wait_nxt = wait_cnt + 1'b1;
      end
    end
  end

  // Branch/jump condition from IR[11:8] of the instruction being entered.
  always_comb begin
    case (n_cc)
      4'b0000: n_cond = psr[1];
      4'b0001: n_cond = ~psr[1];
      4'b0010: n_cond = psr[0];
      4'b0011: n_cond = ~psr[0];
      4'b1110: n_cond = 1'b1;
      default: n_cond = 1'b0;
    endcase
  end

  // Outputs for the state being entered; registered in the state register.
  always_comb begin
    ctl_nxt = '0;
    case (state_nxt)
      S_FETCH: begin
        ctl_nxt.mem_req = 1'b1;
        ctl_nxt.rom_mux = 1'b1;
      end
      S_DECODE: begin
        ctl_nxt.ir_load = 1'b1;
        ctl_nxt.pc_en   = 1'b1;
      end
      S_EXECUTE: begin
        ctl_nxt.alu_buf = 1'b1;
        ctl_nxt.reg_we  = (n_aop4 != 4'b1011);   // CMP/CMPI only set flags
        ctl_nxt.rdst    = ir_nxt[8 +: REGWIDTH];
        ctl_nxt.rsrc    = ir_nxt[0 +: REGWIDTH];
        if (n_itype) begin
          ctl_nxt.imm_mux = 1'b1;
          ctl_nxt.imm     = ir_nxt[0 +: IMMWIDTH];
          ctl_nxt.alu_op  = ir_nxt[12 +: ALUOPWIDTH];
        end else begin
          ctl_nxt.alu_op  = ir_nxt[4 +: ALUOPWIDTH];
        end
      end
      S_BRANCH: if (n_cond) begin
        ctl_nxt.branch = 1'b1;
        ctl_nxt.imm    = ir_nxt[0 +: IMMWIDTH];
      end
      S_JUMP: ctl_nxt.jump = n_cond;
      S_JMPAL: begin
        ctl_nxt.jump   = 1'b1;
        ctl_nxt.ra_buf = 1'b1;
        ctl_nxt.reg_we = 1'b1;
        ctl_nxt.rdst   = ir_nxt[8 +: REGWIDTH];
      end
      S_LOAD0: begin
        ctl_nxt.mem_req  = 1'b1;
        ctl_nxt.sram_mux = 1'b1;
        ctl_nxt.rsrc     = ir_nxt[0 +: REGWIDTH];
      end
      S_LOAD1: begin
        ctl_nxt.sram_buf = 1'b1;
        ctl_nxt.reg_we   = 1'b1;
        ctl_nxt.rdst     = ir_nxt[8 +: REGWIDTH];
      end
      S_STORE: begin
        ctl_nxt.mem_req  = 1'b1;
        ctl_nxt.mem_we   = 1'b1;
        ctl_nxt.sram_mux = 1'b1;
        ctl_nxt.rsrc     = ir_nxt[0 +: REGWIDTH];
        ctl_nxt.rdst     = ir_nxt[8 +: REGWIDTH];
      end
      default: ctl_nxt = '0;
    endcase
  end

  assign ir_load  = ctl_q.ir_load;
  assign pc_en    = ctl_q.pc_en;
  assign mem_req  = ctl_q.mem_req;
  assign mem_we   = ctl_q.mem_we;
  assign reg_we   = ctl_q.reg_we;
  assign BRANCH   = ctl_q.branch;
  assign JUMP     = ctl_q.jump;
  assign RA_BUF   = ctl_q.ra_buf;
  assign ROM_MUX  = ctl_q.rom_mux;
  assign SRAM_BUF = ctl_q.sram_buf;
  assign SRAM_MUX = ctl_q.sram_mux;
  assign ALU_BUF  = ctl_q.alu_buf;
  assign IMM_MUX  = ctl_q.imm_mux;
  assign rDst     = ctl_q.rdst;
  assign rSrc     = ctl_q.rsrc;
  assign imm_val  = ctl_q.imm;
  assign ALU_OP   = ctl_q.alu_op;

endmodule
